// File: rtl/pc_stack_unit_if.sv
// Decoder-side bundle for pc_stack_unit: advance strobe, branch requests,
// branch target, and the PC/stack status returned by the unit.
interface pc_stack_unit_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned DW = $clog2(DEPTH) + 1;

    logic          PC_ENB;
    logic          JMP_flag;
    logic          CALL_flag;
    logic          RET_flag;
    logic [31:0]   Mini_ALU_result;
    logic [15:0]   PC_pos;
    logic [DW-1:0] stack_depth;
    logic          busy;
    logic          overflow_err;
    logic          underflow_err;

    modport master (
        output PC_ENB, JMP_flag, CALL_flag, RET_flag, Mini_ALU_result,
        input  PC_pos, stack_depth, busy, overflow_err, underflow_err
    );

    modport slave (
        input  PC_ENB, JMP_flag, CALL_flag, RET_flag, Mini_ALU_result,
        output PC_pos, stack_depth, busy, overflow_err, underflow_err
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return stack: sequential step, jump,
// call and two-cycle return, with sticky overflow/underflow faults.
module pc_stack_unit #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_stack_unit_if.slave   bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;
    localparam logic [DW-1:0] DepthFull = DW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRetRd, StFault} state_e;

    state_e        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [15:0]   stack_q [DEPTH];
    logic          push;
    logic [AW-1:0] push_addr;
    logic [15:0]   pc_inc;
    logic [15:0]   target;
    logic          unused_alu;

    assign pc_inc     = pc_q + 16'd1;
    assign target     = bus_io.Mini_ALU_result[15:0];
    assign unused_alu = ^bus_io.Mini_ALU_result[31:16];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        push      = 1'b0;
        push_addr = depth_q[AW-1:0];
        unique case (state_q)
            StIdle: begin
                if (bus_io.PC_ENB) begin
                    if (bus_io.RET_flag) begin
                        if (depth_q == '0) begin
                            udf_d   = 1'b1;
                            state_d = StFault;
                        end else begin
                            depth_d = depth_q - 1'b1;
                            state_d = StRetRd;
                        end
                    end else if (bus_io.CALL_flag) begin
                        if (depth_q == DepthFull) begin
                            ovf_d   = 1'b1;
                            state_d = StFault;
                        end else begin
                            push    = 1'b1;
                            depth_d = depth_q + 1'b1;
                            pc_d    = target;
                        end
                    end else if (bus_io.JMP_flag) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            StRetRd: begin
                // depth_q was already decremented, so it indexes the popped entry
                pc_d    = stack_q[depth_q[AW-1:0]];
                state_d = StIdle;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFault;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is never cleared; only a CALL outside reset writes it.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            stack_q[push_addr] <= pc_inc;
        end
    end

    assign bus_io.PC_pos        = pc_q;
    assign bus_io.stack_depth   = depth_q;
    assign bus_io.busy          = (state_q != StIdle);
    assign bus_io.overflow_err  = ovf_q;
    assign bus_io.underflow_err = udf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed test of pc_stack_unit: stepping, wrap, jump, call/return,
// flag priority, overflow and underflow faults, and reset recovery.
module tb_pc_stack_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pc_stack_unit_if #(.DEPTH(16)) bus ();

    pc_stack_unit #(
        .DEPTH    (16),
        .RESET_PC (16'h0000)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic enb, input logic jmp, input logic call, input logic ret,
                         input logic [15:0] tgt);
        bus.PC_ENB          = enb;
        bus.JMP_flag        = jmp;
        bus.CALL_flag       = call;
        bus.RET_flag        = ret;
        bus.Mini_ALU_result = {16'hDEAD, tgt};
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc"}, 32'(bus.PC_pos), 32'h0000);
        check_eq({tag, "_depth"}, 32'(bus.stack_depth), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_ovf"}, 32'(bus.overflow_err), 32'd0);
        check_eq({tag, "_udf"}, 32'(bus.underflow_err), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc();
        cyc();
        check_reset_state("rst");

        // Sequential stepping
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check_eq($sformatf("step%0d_pc", i), 32'(bus.PC_pos), 32'(i));
            check_eq($sformatf("step%0d_busy", i), 32'(bus.busy), 32'd0);
        end

        // PC_ENB low holds state regardless of flags
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
        cyc();
        check_eq("hold_pc", 32'(bus.PC_pos), 32'h0003);
        check_eq("hold_depth", 32'(bus.stack_depth), 32'd0);
        check_eq("hold_busy", 32'(bus.busy), 32'd0);

        // Jump to top of address space, then wrap
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        cyc();
        check_eq("jmp_pc", 32'(bus.PC_pos), 32'hFFFF);
        check_eq("jmp_depth", 32'(bus.stack_depth), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc();
        check_eq("wrap_pc", 32'(bus.PC_pos), 32'h0000);

        // Call from 0x0010 to 0x0200, then return
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010);
        cyc();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0200);
        cyc();
        check_eq("call_pc", 32'(bus.PC_pos), 32'h0200);
        check_eq("call_depth", 32'(bus.stack_depth), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc();
        check_eq("ret1_busy", 32'(bus.busy), 32'd1);
        check_eq("ret1_pc_hold", 32'(bus.PC_pos), 32'h0200);
        check_eq("ret1_depth", 32'(bus.stack_depth), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h7777); // ignored while busy
        cyc();
        check_eq("ret2_pc", 32'(bus.PC_pos), 32'h0011);
        check_eq("ret2_busy", 32'(bus.busy), 32'd0);
        check_eq("ret2_depth", 32'(bus.stack_depth), 32'd0);

        // Priority: RET wins over CALL and JMP
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h003F);
        cyc();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0100);
        cyc();
        check_eq("pri_call_depth", 32'(bus.stack_depth), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0500);
        cyc();
        check_eq("pri_busy", 32'(bus.busy), 32'd1);
        check_eq("pri_depth", 32'(bus.stack_depth), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc();
        check_eq("pri_pc", 32'(bus.PC_pos), 32'h0040);
        check_eq("pri_busy2", 32'(bus.busy), 32'd0);

        // Fill the stack, then overflow
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h1000 + 16'(i));
            cyc();
        end
        check_eq("full_depth", 32'(bus.stack_depth), 32'd16);
        check_eq("full_pc", 32'(bus.PC_pos), 32'h100F);
        check_eq("full_ovf", 32'(bus.overflow_err), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h2000);
        cyc();
        check_eq("ovf_err", 32'(bus.overflow_err), 32'd1);
        check_eq("ovf_busy", 32'(bus.busy), 32'd1);
        check_eq("ovf_pc", 32'(bus.PC_pos), 32'h100F);
        check_eq("ovf_depth", 32'(bus.stack_depth), 32'd16);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc();
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc();
        check_eq("fault_pc", 32'(bus.PC_pos), 32'h100F);
        check_eq("fault_depth", 32'(bus.stack_depth), 32'd16);
        check_eq("fault_udf", 32'(bus.underflow_err), 32'd0);

        // Reset clears the fault; then underflow from an empty stack
        rst_n = 1'b0;
        cyc();
        check_reset_state("rst2");
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc();
        check_eq("udf_err", 32'(bus.underflow_err), 32'd1);
        check_eq("udf_busy", 32'(bus.busy), 32'd1);
        check_eq("udf_pc", 32'(bus.PC_pos), 32'h0000);
        check_eq("udf_ovf", 32'(bus.overflow_err), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc();
        check_eq("udf_frozen_pc", 32'(bus.PC_pos), 32'h0000);

        // Single-edge reset while in FAULT, then stepping resumes
        rst_n = 1'b0;
        cyc();
        check_reset_state("rst3");
        rst_n = 1'b1;
        cyc();
        check_eq("resume_pc1", 32'(bus.PC_pos), 32'h0001);
        cyc();
        check_eq("resume_pc2", 32'(bus.PC_pos), 32'h0002);
        check_eq("resume_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of return-stack entries (power of two, 2..64).
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the PC value loaded on reset.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 PC_ENB  input  1  advance strobe, one per retired instruction.
REQ-006 JMP_flag  input  1  jump request from the program decoder.
REQ-007 CALL_flag  input  1  call request from the program decoder.
REQ-008 RET_flag  input  1  return request from the program decoder.
REQ-009 Mini_ALU_result  input  32  computed branch target; only bits [15:0] are used.
REQ-010 PC_pos  output  16  current program counter; feeds the decoder and fetch.
REQ-011 stack_depth  output  clog2(DEPTH)+1  number of valid return entries.
REQ-012 busy  output  1  high while PC_ENB is ignored.
REQ-013 overflow_err  output  1  sticky: CALL issued with the stack full.
REQ-014 underflow_err  output  1  sticky: RET issued with the stack empty.

Function
REQ-015 The FSM SHALL have states IDLE, RET_RD and FAULT, and SHALL update state only on the rising edge of clk.
REQ-016 In IDLE with PC_ENB=1, the unit SHALL honour requests in priority RET > CALL > JMP > sequential when more than one flag is set.
REQ-017 Sequential step (no flag set): PC_pos SHALL become PC_pos+1 modulo 2^16 (16'hFFFF wraps to 16'h0000), with a latency of 1 cycle.
REQ-018 JMP: PC_pos SHALL become Mini_ALU_result[15:0] in the next cycle, and stack_depth SHALL be unchanged.
REQ-019 CALL with stack_depth<DEPTH: in one cycle the unit SHALL write (PC_pos+1) mod 2^16 into entry[stack_depth], increment stack_depth and set PC_pos to Mini_ALU_result[15:0].
REQ-020 CALL with stack_depth==DEPTH: the unit SHALL set overflow_err, enter FAULT, and leave PC_pos and the stack unchanged.
REQ-021 RET with stack_depth>0: the unit SHALL decrement stack_depth, go to RET_RD and hold PC_pos.
REQ-022 In RET_RD, PC_pos SHALL load entry[stack_depth] (the popped entry), the FSM SHALL return to IDLE, and the RET latency SHALL be 2 cycles.
REQ-023 RET with stack_depth==0: the unit SHALL set underflow_err, enter FAULT, and leave PC_pos unchanged.
REQ-024 busy SHALL be 1 in RET_RD and FAULT and 0 in IDLE; PC_ENB and all flags SHALL be ignored while busy=1.
REQ-025 FAULT SHALL be terminal until reset: PC_pos frozen and stack contents unchanged.
REQ-026 In IDLE with PC_ENB=0, the unit SHALL hold all state regardless of the flags.
REQ-027 Stack storage SHALL be written only by CALL and SHALL never be cleared.

Reset
REQ-028 When rst_n=0 at a rising edge, the unit SHALL set PC_pos=RESET_PC, stack_depth=0, busy=0, overflow_err=0, underflow_err=0 and state IDLE.
REQ-029 Reset SHALL take precedence over every in-flight operation, including RET_RD and FAULT.
REQ-030 Stack entry contents need not be reset.

Verification
REQ-031 Reset, then 3 PC_ENB pulses with no flags -> PC_pos=0,1,2,3 and busy stays 0.
REQ-032 PC_pos=16'hFFFF, PC_ENB with no flag -> PC_pos=16'h0000.
REQ-033 PC_pos=0x0010, CALL with target 0x0200 -> PC_pos=0x0200 and stack_depth=1; later RET -> busy=1 for one cycle, then PC_pos=0x0011 and stack_depth=0.
REQ-034 JMP+CALL+RET asserted together with stack_depth=1 holding 0x0040 -> RET taken: PC_pos=0x0040 after 2 cycles, stack_depth=0.
REQ-035 16 nested CALLs, then a 17th -> overflow_err=1, busy=1, and PC_pos frozen at the 16th target despite further PC_ENB.
REQ-036 RET from empty, then rst_n low for one edge while in FAULT -> underflow_err=1 before reset; after reset all outputs at reset values and normal stepping resumes.
